rom_fetch_ctrl: RTL and testbench

//  Initiator for the asynchronous ROM port: drives ADB, active-low CS and OE, and samples DATAB.
//  On START it bursts LEN consecutive words from START_ADDR, one access per word.

---
 rtl/rom_if_pkg.sv | 29 ++
 rtl/rom_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_if_pkg
//  Description : Shared types and constants for the asynchronous ROM fetch
//                controller: FSM state encoding, default bus geometry and
//                chip-select polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    FIN    = 2'd3
  } fetch_state_t;

  localparam int ROM_DEPTH = 8;
  localparam int ROM_WIDTH = 5;

  // Chip select is active low on the ROM side.
  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;

  // Access timer width; holds WAIT_CYC values 1..15.
  localparam int TIMER_W = 4;

endpackage : rom_if_pkg
`default_nettype wire

// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_ctrl
//  Description : Burst initiator for an asynchronous ROM. Reads LEN words
//                from START_ADDR (address wraps), holds CS/OE for WAIT_CYC
//                cycles per access, and hands each word to the consumer
//                over a VALID/READY handshake. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl
  import rom_if_pkg::*;
#(
  parameter int DEPTH    = ROM_DEPTH,
  parameter int WIDTH    = ROM_WIDTH,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_addr_i,
  input  logic [WIDTH:0]   len_i,
  output logic [DEPTH-1:0] word_out_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] adb_o,
  output logic             cs_o,
  output logic             oe_o,
  input  logic [DEPTH-1:0] datab_i
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WAIT_CYC);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [WIDTH-1:0]   ADDR_ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]     REM_ONE    = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0]     REM_ZERO   = '0;

  fetch_state_t         state_q, state_d;
  logic [WIDTH-1:0]     adb_q,   adb_d;
  logic                 cs_q,    cs_d;
  logic                 oe_q,    oe_d;
  logic [DEPTH-1:0]     word_q,  word_d;
  logic                 valid_q, valid_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [WIDTH:0]       rem_q,   rem_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  // Next-state logic: burst sequencing, access timing and handshake.
  always_comb begin
    state_d = state_q;
    adb_d   = adb_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    word_d  = word_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    timer_d = timer_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != REM_ZERO) begin
            state_d = ACCESS;
            adb_d   = start_addr_i;
            cs_d    = CS_ON;
            oe_d    = 1'b1;
            rem_d   = len_i;
            timer_d = TIMER_LOAD;
          end else begin
            // Empty burst: complete without touching the ROM.
            state_d = FIN;
          end
        end
      end

      ACCESS: begin
        if (timer_q == TIMER_ONE) begin
          // Data has settled for WAIT_CYC cycles; capture and release the ROM.
          word_d  = datab_i;
          valid_d = 1'b1;
          cs_d    = CS_OFF;
          oe_d    = 1'b0;
          state_d = HOLD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      HOLD: begin
        if (valid_q && word_ready_i) begin
          valid_d = 1'b0;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = FIN;
          end else begin
            adb_d   = adb_q + ADDR_ONE;
            cs_d    = CS_ON;
            oe_d    = 1'b1;
            timer_d = TIMER_LOAD;
            state_d = ACCESS;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_d    = CS_OFF;
        oe_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      adb_q   <= '0;
      cs_q    <= CS_OFF;
      oe_q    <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      adb_q   <= adb_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
    end
  end

  assign word_out_o   = word_q;
  assign word_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign adb_o        = adb_q;
  assign cs_o         = cs_q;
  assign oe_o         = oe_q;

endmodule : rom_fetch_ctrl
`default_nettype wire

// File: tb/tb_rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_fetch_ctrl
//  Description : Self-checking bench. Two controllers (WAIT_CYC=1 and 3)
//                share one stimulus stream, each with its own ROM port.
//                A cycle-level behavioural model tracks both, plus directed
//                literal expectations per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [4:0]       start_addr;
  logic [5:0]       len;
  logic             ready;

  logic [1:0][7:0]  word;
  logic [1:0]       valid, busy, done, cs, oe;
  logic [1:0][4:0]  adb;
  wire  [1:0][7:0]  datab;

  logic [7:0]       mem [32];

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  initial for (int a = 0; a < 32; a++) mem[a] = 8'(3 * a + 1);

  // ROM models: drive the bus only while selected and output-enabled.
  assign datab[0] = (!cs[0] && oe[0]) ? mem[adb[0]] : 8'hzz;
  assign datab[1] = (!cs[1] && oe[1]) ? mem[adb[1]] : 8'hzz;

  rom_fetch_ctrl #(.DEPTH(8), .WIDTH(5), .WAIT_CYC(1)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
    .len_i(len), .word_out_o(word[0]), .word_valid_o(valid[0]),
    .word_ready_i(ready), .busy_o(busy[0]), .done_o(done[0]), .adb_o(adb[0]),
    .cs_o(cs[0]), .oe_o(oe[0]), .datab_i(datab[0])
  );

  rom_fetch_ctrl #(.DEPTH(8), .WIDTH(5), .WAIT_CYC(3)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
    .len_i(len), .word_out_o(word[1]), .word_valid_o(valid[1]),
    .word_ready_i(ready), .busy_o(busy[1]), .done_o(done[1]), .adb_o(adb[1]),
    .cs_o(cs[1]), .oe_o(oe[1]), .datab_i(datab[1])
  );

  function automatic int wait_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] rom_word(int a);
    return 8'(3 * (a % 32) + 1);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_busy [2];
  bit   m_en   [2];
  bit   m_valid[2];
  bit   m_fin  [2];
  int   m_addr [2];
  int   m_left [2];
  int   m_age  [2];
  logic [7:0] m_word [2];

  // Model: advance on each rising edge from the inputs presented before it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_en[i] = 0; m_valid[i] = 0; m_fin[i] = 0;
        m_addr[i] = 0; m_left[i] = 0; m_age[i] = 0; m_word[i] = 8'h00;
      end else if (m_fin[i]) begin
        m_fin[i]  = 0;
        m_busy[i] = 0;
      end else if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] = 1;
          if (len == 0) m_fin[i] = 1;
          else begin
            m_addr[i] = int'(start_addr); m_left[i] = int'(len);
            m_en[i] = 1; m_age[i] = 0;
          end
        end
      end else if (m_en[i]) begin
        m_age[i]++;
        if (m_age[i] == wait_of(i)) begin
          m_en[i] = 0; m_valid[i] = 1; m_word[i] = rom_word(m_addr[i]);
        end
      end else if (m_valid[i] && ready) begin
        m_valid[i] = 0;
        m_left[i]--;
        if (m_left[i] == 0) m_fin[i] = 1;
        else begin
          m_addr[i] = (m_addr[i] + 1) % 32;
          m_en[i] = 1; m_age[i] = 0;
        end
      end
    end
  end

  // Compare: every cycle, full registered output set against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model%0d", i),
            {14'd0, cs[i], oe[i], adb[i], valid[i], word[i], busy[i], done[i]},
            {14'd0, !m_en[i], m_en[i], 5'(m_addr[i]), m_valid[i], m_word[i],
             m_busy[i], m_fin[i]});
      end
    end
  end

  // ---------------- traffic monitor ----------------
  logic [7:0] wlog [2][256];
  logic [4:0] alog [2][256];
  int         rlog [2][256];
  int         wcnt [2] = '{0, 0};
  int         dcnt [2] = '{0, 0};
  int         rcnt [2] = '{0, 0};
  int         run  [2] = '{0, 0};

  // Monitor: log accepted words, DONE pulses and CS-low run lengths.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && ready) begin
        wlog[i][wcnt[i] % 256] = word[i];
        alog[i][wcnt[i] % 256] = adb[i];
        wcnt[i]++;
      end
      if (done[i]) dcnt[i]++;
      if (!cs[i]) run[i]++;
      else if (run[i] != 0) begin
        rlog[i][rcnt[i] % 256] = run[i];
        rcnt[i]++;
        run[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy != 2'b00 && n < 400);
    checks++;
    if (busy != 2'b00) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 00", busy, n);
    end
    tick();
  endtask

  task automatic launch(logic [4:0] a, logic [5:0] l);
    start_addr = a; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int wb [2];
  int db [2];
  int rb [2];

  task automatic mark();
    for (int i = 0; i < 2; i++) begin
      wb[i] = wcnt[i]; db[i] = dcnt[i]; rb[i] = rcnt[i];
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; ready = 1'b1;
    tick(2);
    chk_en = 1'b1;
    chk("reset_idle", {cs, oe, valid, busy, done}, {2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    rst_n = 1'b1;
    tick();

    // 1: reset mid-burst
    start_addr = 5'd0; len = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    chk("midburst_busy", {30'd0, busy}, 32'h3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("rst_cs_oe", {28'd0, cs, oe}, {28'd0, 2'b11, 2'b00});
    chk("rst_valid_busy", {28'd0, valid, busy}, 32'h0);
    chk("rst_adb_word", {6'd0, adb, word}, 32'h0);
    tick();
    chk("post_rst_idle", {26'd0, busy, cs, done}, {26'd0, 2'b00, 2'b11, 2'b00});

    // 2: single read at address 4
    mark();
    launch(5'd4, 6'd1);
    chk("single_access_cs", {30'd0, cs}, 32'h0);
    tick();
    chk("single_valid0", {31'd0, valid[0]}, 32'h1);
    chk("single_word0", {24'd0, word[0]}, 32'h0D);
    tick();
    chk("single_done0", {31'd0, done[0]}, 32'h1);
    tick();
    chk("single_idle0", {30'd0, done[0], busy[0]}, 32'h0);
    wait_idle();
    chk("single_word1", {24'd0, wlog[1][wb[1] % 256]}, 32'h0D);
    chk("single_dones", dcnt[0] - db[0] + 2 * (dcnt[1] - db[1]), 32'd3);

    // 3: backpressure, three words from address 0
    mark();
    ready = 1'b0;
    launch(5'd0, 6'd3);
    tick(5);
    chk("bp_hold_valid", {30'd0, valid}, 32'h3);
    chk("bp_hold_word", {16'd0, word}, 32'h0101);
    chk("bp_hold_cs", {30'd0, cs}, 32'h3);
    ready = 1'b1;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("bp_count%0d", i), wcnt[i] - wb[i], 32'd3);
      chk($sformatf("bp_words%0d", i),
          {8'd0, wlog[i][wb[i] % 256], wlog[i][(wb[i] + 1) % 256], wlog[i][(wb[i] + 2) % 256]},
          32'h00010407);
    end

    // 4: address wrap from 30
    mark();
    launch(5'd30, 6'd4);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wrap_words%0d", i),
          {wlog[i][wb[i] % 256], wlog[i][(wb[i] + 1) % 256],
           wlog[i][(wb[i] + 2) % 256], wlog[i][(wb[i] + 3) % 256]},
          32'h5B5E0104);
      chk($sformatf("wrap_addrs%0d", i),
          {3'd0, alog[i][wb[i] % 256], 3'd0, alog[i][(wb[i] + 1) % 256],
           3'd0, alog[i][(wb[i] + 2) % 256], 3'd0, alog[i][(wb[i] + 3) % 256]},
          32'h1E1F0001);
      chk($sformatf("wrap_done%0d", i), dcnt[i] - db[i], 32'd1);
    end

    // 5a: zero-length burst
    mark();
    launch(5'd7, 6'd0);
    chk("len0_done_busy", {28'd0, done, busy}, {28'd0, 2'b11, 2'b11});
    chk("len0_cs", {30'd0, cs}, 32'h3);
    tick();
    chk("len0_after", {28'd0, done, busy}, 32'h0);
    chk("len0_no_access", (rcnt[0] - rb[0]) + (rcnt[1] - rb[1]) + run[0] + run[1], 32'd0);

    // 5b: START held while busy is ignored
    mark();
    start_addr = 5'd2; len = 6'd2; start = 1'b1;
    tick();
    start_addr = 5'd9; len = 6'd5;
    tick(2);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy_start_count%0d", i), wcnt[i] - wb[i], 32'd2);
      chk($sformatf("busy_start_words%0d", i),
          {16'd0, wlog[i][wb[i] % 256], wlog[i][(wb[i] + 1) % 256]}, 32'h070A);
    end

    // 6: access length follows WAIT_CYC, address 10
    mark();
    launch(5'd10, 6'd2);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wait_words%0d", i),
          {16'd0, wlog[i][wb[i] % 256], wlog[i][(wb[i] + 1) % 256]}, 32'h1F22);
      chk($sformatf("wait_runs%0d", i), rcnt[i] - rb[i], 32'd2);
      chk($sformatf("wait_len%0d", i),
          {rlog[i][rb[i] % 256][15:0], rlog[i][(rb[i] + 1) % 256][15:0]},
          (i == 0) ? 32'h00010001 : 32'h00030003);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_rom_fetch_ctrl
`default_nettype wire
